// File: rtl/video_fade_pkg.sv
// Shared types and constants for the video fade stage.
// Brightness is an 8-bit level; 0 is black and 255 is full intensity.
package video_fade_pkg;

   typedef enum logic [1:0] {
      BLACK    = 2'd0,
      FADE_IN  = 2'd1,
      ON       = 2'd2,
      FADE_OUT = 2'd3
   } fade_state_t;

   localparam logic [7:0] LEVEL_MAX = 8'hFF;
   localparam logic [7:0] LEVEL_MIN = 8'h00;

endpackage

// File: rtl/fade_channel_scale.sv
// One colour channel: out = (c * (level + 1)) >> 8, in two register stages.
// Stage 1 holds the 17-bit product; stage 2 holds the shifted result.
module fade_channel_scale
(
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] level,
   input  logic [7:0] c_in,
   output logic [7:0] c_out
);

   logic [16:0] r_prod;
   logic [16:0] w_prod;

   assign w_prod = {9'd0, c_in} * ({9'd0, level} + 17'd1);

   // The product never exceeds 255*256, so bit 16 only ever guards the result.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_prod <= '0;
         c_out  <= '0;
      end else begin
         r_prod <= w_prod;
         c_out  <= r_prod[16] ? 8'hFF : r_prod[15:8];
      end
   end

endmodule

// File: rtl/video_fade.sv
// Per-frame fade-in/fade-out of the video output, with sync, blank and
// data-enable delayed to stay aligned with the 2-cycle colour pipeline.
module video_fade
   import video_fade_pkg::*;
#(
   parameter logic [7:0] LEVEL_STEP = 8'd8
)
(
   input  logic        clk_vid_33_095,
   input  logic        reset,
   input  logic        fade_out_req,
   input  logic        in_hsync,
   input  logic        in_vsync,
   input  logic        in_hblank,
   input  logic        in_vblank,
   input  logic        in_de,
   input  logic [23:0] in_rgb,
   output logic        hsync,
   output logic        vsync,
   output logic        hblank,
   output logic        vblank,
   output logic        de,
   output logic [23:0] rgb,
   output logic [7:0]  fade_level,
   output logic        fade_busy,
   output fade_state_t fade_state
);

   logic        r_vsync_prev;
   logic        w_tick;
   fade_state_t r_state;
   fade_state_t w_state_nxt;
   logic [7:0]  r_level;
   logic [7:0]  w_level_nxt;
   logic        r_busy;
   logic [8:0]  w_add9;
   logic [8:0]  w_sub9;
   logic [7:0]  w_sat_add;
   logic [7:0]  w_sat_sub;
   logic [4:0]  r_sync_d1;
   logic [4:0]  r_sync_d2;

   assign w_tick = in_vsync & ~r_vsync_prev;

   // Carry out of the 9-bit add means overflow; bit 8 set after subtract means underflow.
   assign w_add9    = {1'b0, r_level} + {1'b0, LEVEL_STEP};
   assign w_sub9    = {1'b0, r_level} - {1'b0, LEVEL_STEP};
   assign w_sat_add = w_add9[8] ? LEVEL_MAX : w_add9[7:0];
   assign w_sat_sub = w_sub9[8] ? LEVEL_MIN : w_sub9[7:0];

   always_comb begin
      w_state_nxt = r_state;
      w_level_nxt = r_level;
      if (w_tick) begin
         case (r_state)
            BLACK: begin
               if (!fade_out_req) begin
                  w_state_nxt = FADE_IN;
                  w_level_nxt = LEVEL_STEP;
               end
            end
            FADE_IN: begin
               if (fade_out_req) begin
                  w_state_nxt = FADE_OUT;
                  w_level_nxt = w_sat_sub;
               end else begin
                  w_level_nxt = w_sat_add;
                  if (w_sat_add == LEVEL_MAX) w_state_nxt = ON;
               end
            end
            ON: begin
               if (fade_out_req) begin
                  w_state_nxt = FADE_OUT;
                  w_level_nxt = LEVEL_MAX - LEVEL_STEP;
               end
            end
            FADE_OUT: begin
               if (!fade_out_req) begin
                  w_state_nxt = FADE_IN;
                  w_level_nxt = w_sat_add;
               end else begin
                  w_level_nxt = w_sat_sub;
                  if (w_sat_sub == LEVEL_MIN) w_state_nxt = BLACK;
               end
            end
            default: begin
               w_state_nxt = BLACK;
               w_level_nxt = LEVEL_MIN;
            end
         endcase
      end
   end

   always_ff @(posedge clk_vid_33_095 or posedge reset) begin
      if (reset) begin
         r_vsync_prev <= 1'b0;
         r_state      <= BLACK;
         r_level      <= LEVEL_MIN;
         r_busy       <= 1'b0;
         r_sync_d1    <= '0;
         r_sync_d2    <= '0;
      end else begin
         r_vsync_prev <= in_vsync;
         r_state      <= w_state_nxt;
         r_level      <= w_level_nxt;
         r_busy       <= (w_state_nxt == FADE_IN) || (w_state_nxt == FADE_OUT);
         r_sync_d1    <= {in_hsync, in_vsync, in_hblank, in_vblank, in_de};
         r_sync_d2    <= r_sync_d1;
      end
   end

   fade_channel_scale u_scale_r (
      .clk   (clk_vid_33_095),
      .reset (reset),
      .level (r_level),
      .c_in  (in_rgb[23:16]),
      .c_out (rgb[23:16])
   );

   fade_channel_scale u_scale_g (
      .clk   (clk_vid_33_095),
      .reset (reset),
      .level (r_level),
      .c_in  (in_rgb[15:8]),
      .c_out (rgb[15:8])
   );

   fade_channel_scale u_scale_b (
      .clk   (clk_vid_33_095),
      .reset (reset),
      .level (r_level),
      .c_in  (in_rgb[7:0]),
      .c_out (rgb[7:0])
   );

   assign {hsync, vsync, hblank, vblank, de} = r_sync_d2;
   assign fade_level = r_level;
   assign fade_busy  = r_busy;
   assign fade_state = r_state;

endmodule
